// File: rtl/pool2x2_stream_pkg.sv
// -----------------------------------------------------------------------------
// pool2x2_stream_pkg
// Shared types and helpers for the 2x2 / stride-2 pooling stage.
//   pool_mode_e : selects signed max or floor-average pooling
//   DATA_W_DEF  : default feature width
//   feature_t   : one signed feature value at the default width
//   addr_width  : counter/address width helper, never narrower than one bit
// -----------------------------------------------------------------------------
package pool2x2_stream_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    localparam int DATA_W_DEF = 8;

    typedef logic signed [DATA_W_DEF-1:0] feature_t;

    // Width needed to count 0..n-1; a 1-bit minimum keeps tiny maps legal.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool2x2_stream_if.sv
// -----------------------------------------------------------------------------
// pool2x2_stream_if
// Feature stream bundle used on both sides of the pooling stage.
//   feature_valid : features carries a pixel this cycle
//   features      : one DATA_W signed value per channel
//   last_feature  : qualifies the final pixel of a frame
// master drives the stream, slave observes it. There is no ready signal:
// the upstream convolution cannot stall.
// -----------------------------------------------------------------------------
interface pool2x2_stream_if #(
    parameter int NUM_CH = 6,
    parameter int DATA_W = 8
);

    logic                             feature_valid;
    logic [NUM_CH-1:0][DATA_W-1:0]    features;
    logic                             last_feature;

    modport master (
        output feature_valid,
        output features,
        output last_feature
    );

    modport slave (
        input feature_valid,
        input features,
        input last_feature
    );

endinterface

// File: rtl/pool2x2_stream_line_buf.sv
// -----------------------------------------------------------------------------
// pool2x2_stream_line_buf
// Single-row buffer holding the horizontal pair results of an even row until
// the matching odd row arrives. Synchronous write, asynchronous read, no reset:
// every entry is written by an even row before the following odd row reads it.
//   i_clk     : clock
//   i_wr_en   : write i_wr_data at i_addr on the rising edge
//   i_addr    : shared read/write address (pair column index)
//   i_wr_data : packed per-channel pair values
//   o_rd_data : combinational read of entry i_addr
// -----------------------------------------------------------------------------
module pool2x2_stream_line_buf #(
    parameter int DEPTH  = 14,
    parameter int WIDTH  = 48,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    output logic [WIDTH-1:0]  o_rd_data
);

    // A 1-entry buffer still gets two slots so the 1-bit address is fully decoded.
    localparam int SLOTS = (DEPTH < 2) ? 2 : DEPTH;

    logic [WIDTH-1:0] mem_q [SLOTS];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_addr];

endmodule

// File: rtl/pool2x2_stream.sv
// -----------------------------------------------------------------------------
// pool2x2_stream
// 2x2 / stride-2 pooling over a raster-ordered feature map, all channels in
// parallel. One pooled pixel is emitted per 2x2 window, registered, as a
// single-cycle pulse the cycle after the window's bottom-right pixel arrives.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (wins over a coincident input)
//   in_if  : input pixel stream from the convolution stage (slave)
//   out_if : pooled pixel stream; last_feature marks the final window (master)
// Parameters: NUM_CH channels, DATA_W signed width, FMAP_W x FMAP_H map,
// MODE = POOL_MAX (signed max) or POOL_AVG (sum of four, arithmetic >>> 2).
// A trailing odd column/row advances the counters but never forms a window.
// -----------------------------------------------------------------------------
module pool2x2_stream
    import pool2x2_stream_pkg::*;
#(
    parameter int         NUM_CH = 6,
    parameter int         DATA_W = DATA_W_DEF,
    parameter int         FMAP_W = 28,
    parameter int         FMAP_H = 28,
    parameter pool_mode_e MODE   = POOL_MAX
) (
    input  logic             i_clk,
    input  logic             i_rst,
    pool2x2_stream_if.slave  in_if,
    pool2x2_stream_if.master out_if
);

    // Average mode keeps one extra bit per pair sum and two for the window sum.
    localparam int PAIR_W    = (MODE == POOL_AVG) ? DATA_W + 1 : DATA_W;
    localparam int SUM_W     = DATA_W + 2;
    localparam int LB_DEPTH  = FMAP_W / 2;
    localparam int LB_ADDR_W = addr_width(LB_DEPTH);
    localparam int COL_W     = addr_width(FMAP_W);
    localparam int ROW_W     = addr_width(FMAP_H);
    // Bottom-right corner of the last complete window in the frame.
    localparam int LAST_COL  = 2 * (FMAP_W / 2) - 1;
    localparam int LAST_ROW  = 2 * (FMAP_H / 2) - 1;

    if (FMAP_W < 2 || FMAP_H < 2 || NUM_CH < 1) begin : g_param_check
        $error("pool2x2_stream: FMAP_W and FMAP_H must be >= 2 and NUM_CH >= 1");
    end

    logic [COL_W-1:0]               col_q, col_d;
    logic [ROW_W-1:0]               row_q, row_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  hold_q, hold_d;
    logic                           out_valid_q, out_valid_d;
    logic                           out_last_q, out_last_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  out_feat_q, out_feat_d;

    logic [NUM_CH-1:0][PAIR_W-1:0]  pair_bus;
    logic [NUM_CH-1:0][PAIR_W-1:0]  lb_rd_bus;
    logic [NUM_CH-1:0][DATA_W-1:0]  pooled_bus;
    logic                           lb_wr_en;
    logic [LB_ADDR_W-1:0]           lb_addr;
    logic                           accept;
    logic                           odd_col;
    logic                           odd_row;
    logic                           fire;

    // The input stream never carries a frame marker we need.
    logic unused_in_last;
    assign unused_in_last = in_if.last_feature;

    assign accept  = in_if.feature_valid;
    assign odd_col = col_q[0];
    assign odd_row = row_q[0];
    assign fire    = accept && odd_col && odd_row;

    // Even rows park their pair results; odd rows read them back at the same slot.
    assign lb_wr_en = accept && odd_col && !odd_row;
    assign lb_addr  = LB_ADDR_W'(col_q >> 1);

    pool2x2_stream_line_buf #(
        .DEPTH  (LB_DEPTH),
        .WIDTH  (NUM_CH * PAIR_W),
        .ADDR_W (LB_ADDR_W)
    ) u_line_buf (
        .i_clk     (i_clk),
        .i_wr_en   (lb_wr_en),
        .i_addr    (lb_addr),
        .i_wr_data (pair_bus),
        .o_rd_data (lb_rd_bus)
    );

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic signed [DATA_W-1:0] in_px;
        logic signed [DATA_W-1:0] hold_px;
        logic signed [PAIR_W-1:0] lb_px;
        logic signed [PAIR_W-1:0] pair_px;

        assign in_px        = $signed(in_if.features[ch]);
        assign hold_px      = $signed(hold_q[ch]);
        assign lb_px        = $signed(lb_rd_bus[ch]);
        assign pair_bus[ch] = pair_px;

        if (MODE == POOL_AVG) begin : g_avg
            assign pair_px = PAIR_W'(hold_px) + PAIR_W'(in_px);
            // Arithmetic shift of the full sum floors toward -inf and always fits DATA_W.
            assign pooled_bus[ch] = DATA_W'((SUM_W'(lb_px) + SUM_W'(pair_px)) >>> 2);
        end else begin : g_max
            assign pair_px        = (hold_px > in_px) ? hold_px : in_px;
            assign pooled_bus[ch] = (lb_px > pair_px) ? lb_px : pair_px;
        end
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        hold_d = hold_q;
        if (accept) begin
            if (col_q == COL_W'(FMAP_W - 1)) begin
                col_d = '0;
                if (row_q == ROW_W'(FMAP_H - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!odd_col) begin
                hold_d = in_if.features;
            end
        end
    end

    // Pooled data is held between pulses; only valid/last are one-cycle.
    always_comb begin
        out_valid_d = fire;
        out_last_d  = fire && (row_q == ROW_W'(LAST_ROW)) && (col_q == COL_W'(LAST_COL));
        out_feat_d  = fire ? pooled_bus : out_feat_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_feat_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_feat_q  <= out_feat_d;
        end
    end

    assign out_if.feature_valid = out_valid_q;
    assign out_if.last_feature  = out_last_q;
    assign out_if.features      = out_feat_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// -----------------------------------------------------------------------------
// tb_pool2x2_stream
// Directed bench for pool2x2_stream. Four instances cover the configurations
// of interest: 4x4 max (1 ch), 2x2 average (1 ch), 28x28 max (6 ch, with
// random input gaps) and 5x5 max (odd map, trailing column/row dropped).
// Monitors collect every output pulse into queues; the main sequence compares
// them against hand-computed values or a small reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pool2x2_stream;
    import pool2x2_stream_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    pool2x2_stream_if #(.NUM_CH(1), .DATA_W(8)) a_in ();
    pool2x2_stream_if #(.NUM_CH(1), .DATA_W(8)) a_out ();
    pool2x2_stream_if #(.NUM_CH(1), .DATA_W(8)) b_in ();
    pool2x2_stream_if #(.NUM_CH(1), .DATA_W(8)) b_out ();
    pool2x2_stream_if #(.NUM_CH(6), .DATA_W(8)) c_in ();
    pool2x2_stream_if #(.NUM_CH(6), .DATA_W(8)) c_out ();
    pool2x2_stream_if #(.NUM_CH(1), .DATA_W(8)) d_in ();
    pool2x2_stream_if #(.NUM_CH(1), .DATA_W(8)) d_out ();

    pool2x2_stream #(.NUM_CH(1), .DATA_W(8), .FMAP_W(4), .FMAP_H(4), .MODE(POOL_MAX)) dut_a (
        .i_clk(clk), .i_rst(rst), .in_if(a_in), .out_if(a_out));
    pool2x2_stream #(.NUM_CH(1), .DATA_W(8), .FMAP_W(2), .FMAP_H(2), .MODE(POOL_AVG)) dut_b (
        .i_clk(clk), .i_rst(rst), .in_if(b_in), .out_if(b_out));
    pool2x2_stream #(.NUM_CH(6), .DATA_W(8), .FMAP_W(28), .FMAP_H(28), .MODE(POOL_MAX)) dut_c (
        .i_clk(clk), .i_rst(rst), .in_if(c_in), .out_if(c_out));
    pool2x2_stream #(.NUM_CH(1), .DATA_W(8), .FMAP_W(5), .FMAP_H(5), .MODE(POOL_MAX)) dut_d (
        .i_clk(clk), .i_rst(rst), .in_if(d_in), .out_if(d_out));

    logic signed [7:0] qa_feat[$];
    logic              qa_last[$];
    logic signed [7:0] qb_feat[$];
    logic              qb_last[$];
    logic [47:0]       qc_feat[$];
    logic              qc_last[$];
    logic signed [7:0] qd_feat[$];
    logic              qd_last[$];

    logic signed [7:0] got_q[$];
    logic              got_last[$];
    int                exp_q[$];

    always @(negedge clk) begin
        if (a_out.feature_valid === 1'b1) begin
            qa_feat.push_back(a_out.features[0]);
            qa_last.push_back(a_out.last_feature);
        end
        if (b_out.feature_valid === 1'b1) begin
            qb_feat.push_back(b_out.features[0]);
            qb_last.push_back(b_out.last_feature);
        end
        if (c_out.feature_valid === 1'b1) begin
            qc_feat.push_back(c_out.features);
            qc_last.push_back(c_out.last_feature);
        end
        if (d_out.feature_valid === 1'b1) begin
            qd_feat.push_back(d_out.features[0]);
            qd_last.push_back(d_out.last_feature);
        end
    end

    task automatic check_output(input string tag, input logic signed [63:0] obs,
                                input logic signed [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_exp4(input int v0, input int v1, input int v2, input int v3);
        exp_q.delete();
        exp_q.push_back(v0);
        exp_q.push_back(v1);
        exp_q.push_back(v2);
        exp_q.push_back(v3);
    endtask

    // Compares got_q/got_last against exp_q; last is expected on the final
    // output only, or on every output when each frame is a single window.
    task automatic check_small(input string tag, input bit all_last);
        check_output({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_output($sformatf("%s_val%0d", tag, i),
                         (i < got_q.size()) ? 64'(got_q[i]) : 64'h7777_0000_0000_0000, exp_q[i]);
            check_output($sformatf("%s_last%0d", tag, i),
                         (i < got_last.size()) ? 64'(got_last[i]) : 64'd9,
                         (all_last || i == exp_q.size() - 1) ? 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        a_in.feature_valid = 1'b0;
        b_in.feature_valid = 1'b0;
        c_in.feature_valid = 1'b0;
        d_in.feature_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus_a(input int px);
        a_in.feature_valid = 1'b1;
        a_in.features[0]   = 8'(px);
        @(negedge clk);
    endtask

    task automatic apply_stimulus_b(input int px);
        b_in.feature_valid = 1'b1;
        b_in.features[0]   = 8'(px);
        @(negedge clk);
    endtask

    task automatic apply_stimulus_c(input logic [47:0] px, input int gaps);
        c_in.feature_valid = 1'b0;
        repeat (gaps) @(negedge clk);
        c_in.feature_valid = 1'b1;
        c_in.features      = px;
        @(negedge clk);
    endtask

    task automatic apply_stimulus_d(input int px);
        d_in.feature_valid = 1'b1;
        d_in.features[0]   = 8'(px);
        @(negedge clk);
    endtask

    function automatic logic [47:0] pix_c(input int r, input int c);
        logic [47:0] v;
        v = '0;
        for (int ch = 0; ch < 6; ch++) begin
            v[ch*8 +: 8] = 8'(r * 37 + c * 11 + ch * 53 + r * c * 3);
        end
        return v;
    endfunction

    // Reference: per-channel signed max of the 2x2 window at (wr, wc).
    function automatic logic [47:0] model_c(input int wr, input int wc);
        logic [47:0] v;
        logic [47:0] p;
        int          m;
        int          x;
        v = '0;
        for (int ch = 0; ch < 6; ch++) begin
            m = -1000;
            for (int k = 0; k < 4; k++) begin
                p = pix_c(2 * wr + k / 2, 2 * wc + k % 2);
                x = int'($signed(p[ch*8 +: 8]));
                if (x > m) m = x;
            end
            v[ch*8 +: 8] = 8'(m);
        end
        return v;
    endfunction

    task automatic check_frame_c(input string tag);
        check_output({tag, "_count"}, qc_feat.size(), 196);
        for (int i = 0; i < 196; i++) begin
            check_output($sformatf("%s_feat%0d", tag, i),
                         (i < qc_feat.size()) ? 64'(qc_feat[i]) : 64'h7777_0000_0000_0000,
                         64'(model_c(i / 14, i % 14)));
            check_output($sformatf("%s_last%0d", tag, i),
                         (i < qc_last.size()) ? 64'(qc_last[i]) : 64'd9,
                         (i == 195) ? 1 : 0);
        end
    endtask

    int neg_frame[16] = '{-128, -5, 3, -20,
                          -7, -100, -30, 2,
                          -1, -1, -1, -2,
                          -1, -1, -2, -1};
    int avg_frames[24] = '{-1, -2, -3, -4,
                           127, 127, 127, 127,
                           -128, -128, -128, -128,
                           1, 1, 1, 2,
                           -1, 0, 0, 0,
                           -2, 5, 100, -50};
    int avg_exp[6] = '{-3, 127, -128, 1, -1, 13};

    initial begin
        rst = 1'b1;
        a_in.feature_valid = 1'b0; a_in.features = '0; a_in.last_feature = 1'b0;
        b_in.feature_valid = 1'b0; b_in.features = '0; b_in.last_feature = 1'b0;
        c_in.feature_valid = 1'b0; c_in.features = '0; c_in.last_feature = 1'b0;
        d_in.feature_valid = 1'b0; d_in.features = '0; d_in.last_feature = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        check_output("rst_valid_a", a_out.feature_valid, 0);
        check_output("rst_last_a", a_out.last_feature, 0);
        check_output("rst_feat_a", a_out.features, 0);
        check_output("rst_feat_c", c_out.features, 0);
        check_output("rst_valid_c", c_out.feature_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] 4x4 max, raster 0..15");
        for (int p = 0; p < 16; p++) apply_stimulus_a(p);
        idle(3);
        got_q = qa_feat; got_last = qa_last;
        set_exp4(5, 7, 13, 15);
        check_small("max4x4", 1'b0);
        qa_feat.delete(); qa_last.delete();

        $display("[TB] 4x4 max, negative values");
        for (int p = 0; p < 16; p++) apply_stimulus_a(neg_frame[p]);
        idle(3);
        got_q = qa_feat; got_last = qa_last;
        set_exp4(-5, 3, -1, -1);
        check_small("maxneg", 1'b0);
        qa_feat.delete(); qa_last.delete();

        $display("[TB] reset at row 1 col 1, coincident with valid");
        for (int p = 0; p < 5; p++) apply_stimulus_a(100);
        a_in.feature_valid = 1'b1;
        a_in.features[0]   = 8'd100;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        check_output("rst_partial_none", qa_feat.size(), 0);
        for (int p = 0; p < 16; p++) apply_stimulus_a(2 * p);
        idle(3);
        got_q = qa_feat; got_last = qa_last;
        set_exp4(10, 14, 26, 30);
        check_small("after_rst", 1'b0);
        qa_feat.delete(); qa_last.delete();

        $display("[TB] 2x2 average windows");
        for (int p = 0; p < 24; p++) apply_stimulus_b(avg_frames[p]);
        idle(3);
        got_q = qb_feat; got_last = qb_last;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(avg_exp[i]);
        check_small("avg", 1'b1);

        $display("[TB] 5x5 max, two frames");
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                apply_stimulus_d((r == 4 || c == 4) ? 120 : r * 5 + c);
        idle(3);
        got_q = qd_feat; got_last = qd_last;
        set_exp4(6, 8, 16, 18);
        check_small("odd_f1", 1'b0);
        qd_feat.delete(); qd_last.delete();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                apply_stimulus_d((r == 4 || c == 4) ? 120 : r * 5 + c + 30);
        idle(3);
        got_q = qd_feat; got_last = qd_last;
        set_exp4(36, 38, 46, 48);
        check_small("odd_f2", 1'b0);

        $display("[TB] 28x28 6ch max, gapless frame");
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                apply_stimulus_c(pix_c(r, c), 0);
        idle(3);
        check_frame_c("c_gapless");
        qc_feat.delete(); qc_last.delete();

        $display("[TB] 28x28 6ch max, random valid gaps");
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                apply_stimulus_c(pix_c(r, c),
                                 ($urandom_range(0, 99) < 30) ? int'($urandom_range(1, 3)) : 0);
        idle(3);
        check_frame_c("c_gaps");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
